// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: opcodes, ALU/mux encodings, FSM states and control word for the multicycle MIPS controller.
// Extended-op entries are only reachable when MIPS_MC_EXT_OPS_EN is defined.
package mips_ctrl_pkg;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_RTYPE = 3'b010;
  localparam logic [2:0] ALU_AND   = 3'b011;
  localparam logic [2:0] ALU_OR    = 3'b100;
  localparam logic [1:0] SRCB_RT     = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;
  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEX   = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11,
    S_BRANCHNE = 4'd12,
    S_ANDIEX   = 4'd13,
    S_ORIEX    = 4'd14
  } state_t;
  typedef struct packed {
    logic       mem_req;
    logic       iord;
    logic       mem_write;
    logic       ir_write;
    logic       pc_write;
    logic       pc_en;
    logic       branch;
    logic       branch_ne;
    logic [1:0] pc_src;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic       zero_ext;
  } ctrl_t;
  // DECODE successor; S_FETCH doubles as the illegal-opcode verdict
  function automatic state_t decode_next(logic [5:0] op);
    case (op)
      OP_LW, OP_SW: return S_MEMADR;
      OP_RTYPE:     return S_EXECUTE;
      OP_BEQ:       return S_BRANCH;
      OP_ADDI:      return S_ADDIEX;
      OP_J:         return S_JUMP;
`ifdef MIPS_MC_EXT_OPS_EN
      OP_BNE:       return S_BRANCHNE;
      OP_ANDI:      return S_ANDIEX;
      OP_ORI:       return S_ORIEX;
`endif
      default:      return S_FETCH;
    endcase
  endfunction
endpackage

// File: rtl/mips_ctrl_outdec.sv
// mips_ctrl_outdec: combinational state-to-control-word decoder (Moore, plus mem_ready/Zero qualifiers).
// BNE/ANDI/ORI states decode only when MIPS_MC_EXT_OPS_EN is defined.
module mips_ctrl_outdec
  import mips_ctrl_pkg::*;
(
  input  logic [3:0]                state,
  input  logic                      mem_ready,
  input  logic                      zero,
  output logic [$bits(ctrl_t)-1:0]  cw
);
  ctrl_t c;
  always_comb begin
    c = '0;
    case (state_t'(state))
      S_FETCH: begin
        c.mem_req = 1'b1;
        c.alu_src_b = SRCB_FOUR;
        c.ir_write = mem_ready;
        c.pc_write = mem_ready;
      end
      S_DECODE: c.alu_src_b = SRCB_IMM_SH;
      S_MEMADR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
      end
      S_MEMRD: begin
        c.mem_req = 1'b1;
        c.iord = 1'b1;
      end
      S_MEMWB: begin
        c.mem_to_reg = 1'b1;
        c.reg_write = 1'b1;
      end
      S_MEMWR: begin
        c.mem_req = 1'b1;
        c.iord = 1'b1;
        c.mem_write = mem_ready;
      end
      S_EXECUTE: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_RT;
        c.alu_op = ALU_RTYPE;
      end
      S_ALUWB: begin
        c.reg_dst = 1'b1;
        c.reg_write = 1'b1;
      end
      S_BRANCH: begin
        c.alu_src_a = 1'b1;
        c.alu_op = ALU_SUB;
        c.branch = 1'b1;
        c.pc_src = PC_ALUOUT;
      end
      S_ADDIEX: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
        c.alu_op = ALU_ADD;
      end
      S_ADDIWB: c.reg_write = 1'b1;
      S_JUMP: begin
        c.pc_src = PC_JUMP;
        c.pc_write = 1'b1;
      end
`ifdef MIPS_MC_EXT_OPS_EN
      S_BRANCHNE: begin
        c.alu_src_a = 1'b1;
        c.alu_op = ALU_SUB;
        c.branch = 1'b1;
        c.branch_ne = 1'b1;
        c.pc_src = PC_ALUOUT;
      end
      S_ANDIEX: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
        c.alu_op = ALU_AND;
        c.zero_ext = 1'b1;
      end
      S_ORIEX: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
        c.alu_op = ALU_OR;
        c.zero_ext = 1'b1;
      end
`endif
      default: ;
    endcase
    c.pc_en = c.pc_write | (c.branch & (zero ^ c.branch_ne));
  end
  assign cw = c;
endmodule

// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl: multicycle MIPS control FSM with memory-ready stalls and illegal-opcode trap.
// Define MIPS_MC_EXT_OPS_EN to add BNE, ANDI and ORI.
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int OPCODE_W = 6,
  parameter int ALUOP_W  = 3,
  parameter int STATE_W  = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                Zero,
  input  logic                mem_ready,
  output logic                mem_req,
  output logic                IorD,
  output logic                MemWrite,
  output logic                IRWrite,
  output logic                PCWrite,
  output logic                PCEn,
  output logic                Branch,
  output logic [1:0]          PCSrc,
  output logic                RegDst,
  output logic                MemtoReg,
  output logic                RegWrite,
  output logic                ALUSrcA,
  output logic [1:0]          ALUSrcB,
  output logic [ALUOP_W-1:0]  ALUOp,
  output logic                illegal_op,
  output logic [STATE_W-1:0]  state_o,
  output logic                ZeroExt
);
  state_t state;
  ctrl_t c;
  always_ff @(posedge clk)
    if (!rst_n) state <= S_FETCH;
    else
      case (state)
        S_FETCH:   state <= mem_ready ? S_DECODE : S_FETCH;
        S_DECODE:  state <= decode_next(opcode[5:0]);
        S_MEMADR:  state <= (opcode[5:0] == OP_LW) ? S_MEMRD : S_MEMWR;
        S_MEMRD:   state <= mem_ready ? S_MEMWB : S_MEMRD;
        S_MEMWR:   state <= mem_ready ? S_FETCH : S_MEMWR;
        S_EXECUTE: state <= S_ALUWB;
        S_ADDIEX:  state <= S_ADDIWB;
`ifdef MIPS_MC_EXT_OPS_EN
        S_ANDIEX:  state <= S_ADDIWB;
        S_ORIEX:   state <= S_ADDIWB;
`endif
        default:   state <= S_FETCH;
      endcase
  mips_ctrl_outdec u_dec (
    .state(state),
    .mem_ready(mem_ready),
    .zero(Zero),
    .cw(c)
  );
  // strobes are held low during reset so an abandoned instruction writes nothing
  assign mem_req    = rst_n & c.mem_req;
  assign MemWrite   = rst_n & c.mem_write;
  assign IRWrite    = rst_n & c.ir_write;
  assign PCWrite    = rst_n & c.pc_write;
  assign PCEn       = rst_n & c.pc_en;
  assign RegWrite   = rst_n & c.reg_write;
  assign illegal_op = rst_n & (state == S_DECODE) & (decode_next(opcode[5:0]) == S_FETCH);
  assign IorD       = c.iord;
  assign Branch     = c.branch;
  assign PCSrc      = c.pc_src;
  assign RegDst     = c.reg_dst;
  assign MemtoReg   = c.mem_to_reg;
  assign ALUSrcA    = c.alu_src_a;
  assign ALUSrcB    = c.alu_src_b;
  assign ALUOp      = ALUOP_W'(c.alu_op);
  assign ZeroExt    = c.zero_ext;
  assign state_o    = STATE_W'(state);
endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
Multicycle successor to the single-cycle MIPS control unit. It is a Moore FSM that sequences each instruction over 3-5 cycles using one shared ALU and one unified instruction/data memory. It adds a memory-ready stall handshake and illegal-opcode trapping. It sits between the instruction register opcode field and the datapath mux, enable and ALU-control inputs.

Parameters:
OPCODE_W, 6, opcode field width
ALUOP_W, 3, ALU operation code width (minimum 3)
STATE_W, 4, state register width (minimum 4)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  synchronous active-low reset
opcode  in  OPCODE_W  IR[31:26], valid from DECODE onward
Zero  in  1  ALU zero flag
mem_ready  in  1  memory completes the current access this cycle
mem_req  out  1  memory access request
IorD  out  1  memory address select: 0=PC, 1=ALUOut
MemWrite  out  1  memory write strobe
IRWrite  out  1  instruction register load
PCWrite  out  1  unconditional PC load
PCEn  out  1  PCWrite | (Branch & Zero)
Branch  out  1  conditional branch
PCSrc  out  2  00=ALU, 01=ALUOut, 10=jump target
RegDst  out  1  1=rd, 0=rt
MemtoReg  out  1  write-back select: 1=memory data
RegWrite  out  1  register file write strobe
ALUSrcA  out  1  0=PC, 1=rs
ALUSrcB  out  2  00=rt, 01=const 4, 10=sign-extended immediate, 11=sign-extended immediate << 2
ALUOp  out  ALUOP_W  000=ADD, 001=SUB, 010=R-type (funct-decoded downstream)
illegal_op  out  1  one-cycle pulse on an undefined opcode
state_o  out  STATE_W  current state, for debug

Behaviour:
- Reset: when rst_n=0 at a clock edge, the state goes to FETCH. While rst_n=0, all strobes (mem_req, MemWrite, IRWrite, PCWrite, PCEn, RegWrite, illegal_op) are forced to 0 combinationally. A reset mid-instruction abandons that instruction with no partial writes.
- Outputs: pure Moore decode of the state, except PCEn, which also depends on Zero. Every output not listed for a state is 0.
- FETCH(0): mem_req=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=ADD, PCSrc=00. IRWrite and PCWrite are asserted only when mem_ready=1. Moves to DECODE on mem_ready, otherwise holds.
- DECODE(1): ALUSrcA=0, ALUSrcB=11, ALUOp=ADD (branch target into ALUOut). Transitions by opcode:
  - 100011 or 101011 -> MEMADR
  - 000000 -> EXECUTE
  - 000100 -> BRANCH
  - 001000 -> ADDIEX
  - 000010 -> JUMP
  - any other opcode: illegal_op=1 and return to FETCH
- MEMADR(2): ALUSrcA=1, ALUSrcB=10, ALUOp=ADD. Goes to MEMRD for LW, MEMWR for SW.
- MEMRD(3): mem_req=1, IorD=1. Holds until mem_ready, then goes to MEMWB.
- MEMWB(4): RegDst=0, MemtoReg=1, RegWrite=1, then FETCH.
- MEMWR(5): mem_req=1, IorD=1, MemWrite=mem_ready. Goes to FETCH on mem_ready.
- EXECUTE(6): ALUSrcA=1, ALUSrcB=00, ALUOp=010, then ALUWB.
- ALUWB(7): RegDst=1, MemtoReg=0, RegWrite=1, then FETCH.
- BRANCH(8): ALUSrcA=1, ALUSrcB=00, ALUOp=SUB, Branch=1, PCSrc=01, then FETCH.
- ADDIEX(9): ALUSrcA=1, ALUSrcB=10, ALUOp=ADD, then ADDIWB.
- ADDIWB(10): RegDst=0, MemtoReg=0, RegWrite=1, then FETCH.
- JUMP(11): PCSrc=10, PCWrite=1, then FETCH.
- Unused state encodings recover to FETCH with all strobes 0.
- Latency with mem_ready held at 1: R-type 4, LW 5, SW 4, BEQ 3, ADDI 4, J 3 cycles. Each stalled cycle adds exactly 1.
- Opcode is sampled only in DECODE and MEMADR. IR stability outside those states does not matter.

Optional Feature:
MIPS_MC_EXT_OPS_EN. When defined:
- BNE (000101) -> BRANCHNE state. Same outputs as BRANCH, except PCEn = Branch & ~Zero.
- ANDI (001100) and ORI (001101) -> ADDIEX path, with ALUOp=011 (AND) or 100 (OR) and a zero-extended immediate (extra output ZeroExt=1).
When undefined: these opcodes are illegal, ZeroExt is tied to 0, and encodings 011/100 are never driven.

Decomposition:
- Package mips_ctrl_pkg holds opcode localparams, the ALUOp encodings, the state enum, and the ALUSrcB/PCSrc encodings.
- One sub-module: mips_ctrl_outdec, a combinational state-to-control-word decoder. The top module keeps the state register and next-state logic.

Test Plan:
- Reset then LW (100011), mem_ready=1 -> state sequence 0,1,2,3,4,0; RegWrite=1 and MemtoReg=1 only in state 4; illegal_op never asserted.
- SW (101011) with mem_ready low for 3 cycles in MEMWR -> state 5 held 4 cycles; MemWrite=1 in exactly 1 cycle; no RegWrite.
- BEQ with Zero=1 -> PCEn=1 in BRANCH, PCSrc=01. Repeat with Zero=0 -> PCEn=0. Total 3 cycles each.
- R-type (000000), J (000010), ADDI (001000) back-to-back -> durations 4/3/4 cycles; ALUOp=010 in EXECUTE; RegDst=1 only for R-type; PCSrc=10 in JUMP.
- Opcode 111111 -> illegal_op single pulse in DECODE, next state FETCH, no write strobes.
- rst_n driven low during MEMRD -> all strobes 0 that cycle, state 0 after the edge; the next fetch proceeds normally.
